// File: rtl/srl_seq_pkg.sv
// Shared types for the SRL delay sequencer: FSM state encoding and counter sizing.
package srl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned selw, input int unsigned wordw);
        return selw + $clog2(wordw) + 1;
    endfunction

endpackage

// File: rtl/dynamic_shift_register.sv
// Clock-enabled serial delay line of depth 2**SELWIDTH with a run-time selectable output tap.
module dynamic_shift_register #(
    parameter int unsigned SELWIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic                SI,
    input  logic [SELWIDTH-1:0] SEL,
    output logic                DO
);

    localparam int unsigned DEPTH = 2 ** SELWIDTH;

    logic [DEPTH-1:0] data_q;
    logic [DEPTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clken) begin
            data_d = (data_q << 1) | DEPTH'(SI);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign DO = data_q[SEL];

endmodule

// File: rtl/srl_delay_sequencer.sv
// Pushes a parallel word MSB-first through a tapped delay line and rebuilds it from the tap,
// reporting the number of enabled RUN cycles taken.
module srl_delay_sequencer
    import srl_seq_pkg::*;
#(
    parameter int unsigned SELWIDTH = 3,
    parameter int unsigned WORDW    = 8,
    parameter int unsigned CNTW     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDW-1:0]    in_data,
    input  logic [SELWIDTH-1:0] in_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDW-1:0]    out_data,
    output logic [CNTW-1:0]     out_cycles,
    output logic                busy
);

    localparam int unsigned CW = cnt_width(SELWIDTH, WORDW);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SELWIDTH-1:0] sel_q, sel_d;
    logic [WORDW-1:0]    tx_q, tx_d;
    logic [WORDW-1:0]    rx_q, rx_d;
    logic [WORDW-1:0]    out_data_q, out_data_d;
    logic [CNTW-1:0]     out_cycles_q, out_cycles_d;

    logic [CW-1:0]       n_last;
    logic [WORDW-1:0]    rx_next;
    logic                sr_clken;
    logic                sr_si;
    logic                sr_do;

    assign n_last  = CW'(WORDW) + CW'(sel_q);
    assign rx_next = (rx_q << 1) | WORDW'(sr_do);

    // The tap bit entered at edge k appears at DO during cnt = k+sel+1, hence the capture window.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        out_data_d   = out_data_q;
        out_cycles_d = out_cycles_q;
        sr_clken     = 1'b0;
        sr_si        = 1'b0;

        if (state_q == RUN && cnt_q < CW'(WORDW)) begin
            sr_si = tx_q[WORDW-1];
        end

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        tx_d    = in_data;
                        sel_d   = in_sel;
                        cnt_d   = '0;
                        rx_d    = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    sr_clken = (cnt_q < n_last);
                    tx_d     = tx_q << 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q > CW'(sel_q)) begin
                        rx_d = rx_next;
                    end
                    if (cnt_q == n_last) begin
                        state_d      = DONE;
                        out_data_d   = rx_next;
                        out_cycles_d = CNTW'(n_last + CW'(1));
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            out_data_q   <= '0;
            out_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            out_data_q   <= out_data_d;
            out_cycles_q <= out_cycles_d;
        end
    end

    dynamic_shift_register #(
        .SELWIDTH(SELWIDTH)
    ) u_dsr (
        .clk  (clk),
        .rst  (~rst_n),
        .clken(sr_clken),
        .SI   (sr_si),
        .SEL  (sel_q),
        .DO   (sr_do)
    );

    assign in_ready   = rst_n && (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_data   = out_data_q;
    assign out_cycles = out_cycles_q;

endmodule

// File: tb/tb_srl_delay_sequencer.sv
// Bench for srl_delay_sequencer: directed scenarios plus a randomized loopback/latency sweep.
module tb_srl_delay_sequencer;

    localparam int unsigned SELWIDTH = 3;
    localparam int unsigned WORDW    = 8;
    localparam int unsigned CNTW     = 8;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic                in_valid;
    logic                in_ready;
    logic [WORDW-1:0]    in_data;
    logic [SELWIDTH-1:0] in_sel;
    logic                out_valid;
    logic                out_ready;
    logic [WORDW-1:0]    out_data;
    logic [CNTW-1:0]     out_cycles;
    logic                busy;

    int checks = 0;
    int passes = 0;
    int last_wait = 0;

    srl_delay_sequencer #(
        .SELWIDTH(SELWIDTH),
        .WORDW   (WORDW),
        .CNTW    (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cycles(out_cycles),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic pick(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    // One full request: accept, run (counting en-high and wall edges), hold in DONE, handshake.
    task automatic run_req(input logic [7:0] d, input logic [2:0] s, input int en_pct,
                           input int rdy_pct, input int gap_at, input int hold,
                           input bit keep_valid, input logic [7:0] nd, input logic [2:0] ns,
                           input int exp_wall);
        int   waits, lat, wall, gap_left, k;
        logic fire;
        int   exp_lat;
        exp_lat = WORDW + s + 1;
        in_data = d; in_sel = s; in_valid = 1'b1; out_ready = 1'b0;
        waits = 0; fire = 1'b0;
        while (!fire && waits < 200) begin
            en   = pick(en_pct);
            fire = en && in_ready;
            waits++;
            tick();
        end
        last_wait = waits;
        chk("accept", fire, 1);
        in_valid = 1'b0; in_data = 8'($urandom); in_sel = 3'($urandom);
        lat = 0; wall = 0; gap_left = 3;
        while (!out_valid && wall < 200) begin
            chk("run_flags", {busy, in_ready}, 2'b10);
            if (gap_at >= 0 && lat == gap_at && gap_left > 0) begin
                en = 1'b0;
                gap_left--;
            end else begin
                en = pick(en_pct);
            end
            if (en) lat++;
            wall++;
            tick();
        end
        chk("out_valid_seen", out_valid, 1);
        chk("latency", lat, exp_lat);
        chk("out_data", out_data, d);
        chk("out_cycles", out_cycles, exp_lat);
        if (exp_wall >= 0) chk("wall_cycles", wall, exp_wall);
        if (keep_valid) begin
            in_valid = 1'b1; in_data = nd; in_sel = ns;
        end
        fire = 1'b0; k = 0;
        while (!fire && k < 200) begin
            chk("done_flags", {out_valid, in_ready, busy}, 3'b101);
            chk("done_data", out_data, d);
            chk("done_cycles", out_cycles, exp_lat);
            if (k < hold) begin
                out_ready = 1'b0; en = 1'b1;
            end else begin
                out_ready = pick(rdy_pct); en = pick(en_pct);
            end
            fire = en && out_ready;
            k++;
            tick();
        end
        chk("handshake", fire, 1);
        out_ready = 1'b0;
        chk("after_hs", {out_valid, busy, in_ready}, 3'b001);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_cycles", out_cycles, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1);

        run_req(8'hA5, 3'd0, 100, 100, -1, 0, 1'b0, 8'h00, 3'd0, 9);

        run_req(8'hFF, 3'd7, 100, 100, -1, 0, 1'b0, 8'h00, 3'd0, 16);
        run_req(8'h3C, 3'd7, 100, 100, -1, 0, 1'b0, 8'h00, 3'd0, 16);

        run_req(8'h81, 3'd4, 100, 100, 5, 0, 1'b0, 8'h00, 3'd0, 16);

        run_req(8'h5A, 3'd3, 100, 100, -1, 5, 1'b1, 8'hC3, 3'd5, -1);
        run_req(8'hC3, 3'd5, 100, 100, -1, 5, 1'b0, 8'h00, 3'd0, -1);
        chk("b2b_accept_wait", last_wait, 1);

        in_data = 8'h96; in_sel = 3'd2; in_valid = 1'b1; en = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_run_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_out_cycles", out_cycles, 0);
        tick(); tick();
        chk("mrst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("mrst_idle_ready", in_ready, 1);
        run_req(8'h4B, 3'd2, 100, 100, -1, 0, 1'b0, 8'h00, 3'd0, 11);

        for (int r = 0; r < 200; r++) begin
            run_req(8'($urandom), 3'($urandom), 70, 50, -1, int'($urandom_range(2)),
                    1'b0, 8'h00, 3'd0, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
